// File: rtl/hv_owt_tx_ctrl.sv
// rtl/hv_owt_tx_ctrl.sv - HV-side OWT frame transmitter; OWT_TX_CRC_ERR_INJ_EN adds CRC fault injection

// Serial CRC8 (x^8+x^2+x+1), MSB first; crc_next is the remainder after absorbing din
module crc8_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc_next
);
    logic [7:0] crc;
    logic [7:0] base;

    // one-bit LFSR step; start discards the previous frame's remainder
    always_comb begin
        base     = start ? 8'h00 : crc;
        crc_next = {base[6:0], 1'b0} ^ ((base[7] ^ din) ? 8'h07 : 8'h00);
    end

    // remainder register, advanced once per transmitted message bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc_next;
        end
    end
endmodule

module hv_owt_tx_ctrl #(
    parameter int OWT_EXT_CYC_NUM     = 4,
    parameter int OWT_SYNC_BIT_NUM    = 12,
    parameter int OWT_TAIL_BIT_NUM    = 4,
    parameter int OWT_CMD_BIT_NUM     = 8,
    parameter int OWT_DATA_BIT_NUM    = 16,
    parameter int OWT_CRC_BIT_NUM     = 8,
    parameter int OWT_TX_GAP_CYC_NUM  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_owt_tx_req,
    input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
    input  logic [OWT_DATA_BIT_NUM-1:0] i_owt_tx_data,
    input  logic                        i_owt_tx_no_data,
`ifdef OWT_TX_CRC_ERR_INJ_EN
    input  logic                        i_owt_tx_crc_err_inj,
`endif
    output logic                        o_owt_tx_ack,
    output logic                        o_owt_tx_busy,
    output logic                        o_owt_tx_done,
    output logic                        o_hv_lv_owt_tx
);
    localparam int TW = (OWT_EXT_CYC_NUM > 1) ? $clog2(OWT_EXT_CYC_NUM) : 1;
    localparam int CW = $clog2(OWT_SYNC_BIT_NUM + OWT_CMD_BIT_NUM + OWT_DATA_BIT_NUM
                               + OWT_CRC_BIT_NUM + OWT_TAIL_BIT_NUM + OWT_TX_GAP_CYC_NUM + 1);
    localparam int SW = OWT_DATA_BIT_NUM;
    localparam logic [3:0] TAIL_PAT = 4'b1100;

    typedef enum logic [2:0] {
        IDLE, SYNC_HEAD, SYNC_TAIL, CMD, DATA, CRC, END_TAIL, GAP
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   timer;
    logic            half;
    logic [CW-1:0]   bit_cnt;
    logic [SW-1:0]   sh;
    logic [SW-1:0]   data_q;
    logic            no_data_q;
    logic            inj_q;
    logic [7:0]      crc_next;
    logic            sym_end, man_end, tail_sym;
    logic            line_d, ack_d, done_d, busy_d;
    logic            crc_start, crc_en;

    assign sym_end   = (timer == TW'(OWT_EXT_CYC_NUM - 1));
    assign man_end   = sym_end && half;
    assign tail_sym  = TAIL_PAT[2'd3 - bit_cnt[1:0]];
    assign crc_start = (state == CMD) && (bit_cnt == '0);
    assign crc_en    = man_end && ((state == CMD) || (state == DATA));

    crc8_serial u_crc (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (crc_start),
        .en       (crc_en),
        .din      (sh[SW-1]),
        .crc_next (crc_next)
    );

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next state and next values of the registered outputs
    always_comb begin
        state_d = state;
        line_d  = 1'b0;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (i_owt_tx_req) begin
                    state_d = SYNC_HEAD;
                    ack_d   = 1'b1;
                end
            end
            SYNC_HEAD: begin
                line_d = half;
                if (man_end && bit_cnt == CW'(OWT_SYNC_BIT_NUM - 1)) state_d = SYNC_TAIL;
            end
            SYNC_TAIL: begin
                line_d = tail_sym;
                if (sym_end && bit_cnt == CW'(OWT_TAIL_BIT_NUM - 1)) state_d = CMD;
            end
            CMD: begin
                line_d = sh[SW-1] ^ half;
                if (man_end && bit_cnt == CW'(OWT_CMD_BIT_NUM - 1)) state_d = no_data_q ? CRC : DATA;
            end
            DATA: begin
                line_d = sh[SW-1] ^ half;
                if (man_end && bit_cnt == CW'(OWT_DATA_BIT_NUM - 1)) state_d = CRC;
            end
            CRC: begin
                line_d = sh[SW-1] ^ half;
                if (man_end && bit_cnt == CW'(OWT_CRC_BIT_NUM - 1)) state_d = END_TAIL;
            end
            END_TAIL: begin
                line_d = tail_sym;
                if (sym_end && bit_cnt == CW'(OWT_TAIL_BIT_NUM - 1)) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (bit_cnt == CW'(OWT_TX_GAP_CYC_NUM - 1)) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // half-bit timer, half-bit phase and the shared bit counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer   <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
        end else if (state_d != state) begin
            timer   <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                SYNC_HEAD, CMD, DATA, CRC: begin
                    timer <= sym_end ? '0 : timer + TW'(1);
                    if (sym_end) half <= ~half;
                    if (man_end) bit_cnt <= bit_cnt + CW'(1);
                end
                SYNC_TAIL, END_TAIL: begin
                    timer <= sym_end ? '0 : timer + TW'(1);
                    if (sym_end) bit_cnt <= bit_cnt + CW'(1);
                end
                GAP: begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
                default: begin
                    timer   <= '0;
                    half    <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // request capture and the field shift register (cmd is parked in it through sync)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh        <= '0;
            data_q    <= '0;
            no_data_q <= 1'b0;
        end else if (state == IDLE && i_owt_tx_req) begin
            sh        <= SW'(i_owt_tx_cmd) << (SW - OWT_CMD_BIT_NUM);
            data_q    <= i_owt_tx_data;
            no_data_q <= i_owt_tx_no_data;
        end else if (state_d != state && state_d == DATA) begin
            sh <= data_q;
        end else if (state_d != state && state_d == CRC) begin
            sh <= SW'(crc_next ^ {7'b0, inj_q}) << (SW - OWT_CRC_BIT_NUM);
        end else if (man_end && (state == CMD || state == DATA || state == CRC)) begin
            sh <= sh << 1;
        end
    end

`ifdef OWT_TX_CRC_ERR_INJ_EN
    // fault-injection flag, frozen for the frame in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inj_q <= 1'b0;
        end else if (state == IDLE && i_owt_tx_req) begin
            inj_q <= i_owt_tx_crc_err_inj;
        end
    end
`else
    assign inj_q = 1'b0;
`endif

    // registered outputs so the line never glitches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hv_lv_owt_tx <= 1'b0;
            o_owt_tx_ack   <= 1'b0;
            o_owt_tx_done  <= 1'b0;
            o_owt_tx_busy  <= 1'b0;
        end else begin
            o_hv_lv_owt_tx <= line_d;
            o_owt_tx_ack   <= ack_d;
            o_owt_tx_done  <= done_d;
            o_owt_tx_busy  <= busy_d;
        end
    end
endmodule

// File: tb/tb_hv_owt_tx_ctrl.sv
// tb/tb_hv_owt_tx_ctrl.sv - self-checking bench for hv_owt_tx_ctrl
module tb_hv_owt_tx_ctrl;
    localparam int EXT = 4;
`ifdef OWT_TX_CRC_ERR_INJ_EN
    localparam bit INJ_EN = 1'b1;
`else
    localparam bit INJ_EN = 1'b0;
`endif

    logic        i_clk, i_rst_n, req, no_data, inj;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        ack, busy, done, line;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_q[$];

    hv_owt_tx_ctrl dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_owt_tx_req     (req),
        .i_owt_tx_cmd     (cmd),
        .i_owt_tx_data    (data),
        .i_owt_tx_no_data (no_data),
`ifdef OWT_TX_CRC_ERR_INJ_EN
        .i_owt_tx_crc_err_inj (inj),
`endif
        .o_owt_tx_ack     (ack),
        .o_owt_tx_busy    (busy),
        .o_owt_tx_done    (done),
        .o_hv_lv_owt_tx   (line)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC as the remainder of message * x^8 divided by x^8+x^2+x+1
    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [15:0] d, input bit nd);
        logic [31:0] r;
        int top;
        if (nd) begin r = {16'h0, c, 8'h0}; top = 15; end
        else    begin r = {c, d, 8'h0};     top = 31; end
        for (int i = top; i >= 8; i--)
            if (r[i]) r = r ^ (32'h107 << (i - 8));
        return r[7:0];
    endfunction

    task automatic put(input bit b);
        repeat (EXT) exp_q.push_back(b);
    endtask

    task automatic manch(input bit b);
        put(b);
        put(!b);
    endtask

    task automatic tail();
        put(1'b1); put(1'b1); put(1'b0); put(1'b0);
    endtask

    // expected per-cycle line waveform of one frame
    task automatic build(input logic [7:0] c, input logic [15:0] d, input bit nd, input bit ij);
        logic [7:0] crc;
        crc = crc_ref(c, d, nd) ^ {7'b0, ij & INJ_EN};
        exp_q.delete();
        repeat (12) manch(1'b0);
        tail();
        for (int i = 7; i >= 0; i--) manch(c[i]);
        if (!nd) for (int i = 15; i >= 0; i--) manch(d[i]);
        for (int i = 7; i >= 0; i--) manch(crc[i]);
        tail();
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!ack && n < 40);
        if (!ack) check("ack_timeout", 32'd0, 32'd1);
    endtask

    // called at the ack cycle; walks the frame and stops on the done cycle
    task automatic check_frame(input logic [7:0] c, input logic [15:0] d, input bit nd,
                               input bit ij, input int chg_at);
        int bad_bits, bad_done, len;
        bad_bits = 0;
        bad_done = 0;
        check("line_at_ack", line, 0);
        build(c, d, nd, ij);
        len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            if (i == chg_at) begin
                cmd     = 8'($urandom);
                data    = 16'($urandom);
                no_data = ~no_data;
                inj     = ~inj;
            end
            @(negedge i_clk);
            if (i == 0) check("ack_pulse", ack, 0);
            if (line !== exp_q[i]) bad_bits++;
            if (done && i != len - 1) bad_done++;
            if (i == len - 1) begin
                check("done_last", done, 1);
                check("busy_at_done", busy, 1);
            end
        end
        check("frame_bits", bad_bits, 0);
        check("done_early", bad_done, 0);
    endtask

    task automatic gap_tail();
        int n, bad;
        n = 0;
        bad = 0;
        forever begin
            @(negedge i_clk);
            if (line) bad++;
            if (!busy || n > 30) break;
            n++;
        end
        check("busy_tail", n, 7);
        check("gap_line", bad, 0);
    endtask

    task automatic single(input logic [7:0] c, input logic [15:0] d, input bit nd, input bit ij);
        int n;
        cmd = c; data = d; no_data = nd; inj = ij;
        req = 1'b1;
        wait_ack(n);
        check("ack_latency", n, 1);
        req = 1'b0;
        check_frame(c, d, nd, ij, -1);
        gap_tail();
    endtask

    initial begin
        int n, act, bad;
        logic [7:0]  c2;
        logic [15:0] d2;
        bit          nd2, ij2;

        i_rst_n = 1'b0; req = 1'b0; cmd = '0; data = '0; no_data = 1'b0; inj = 1'b0;
        repeat (5) @(negedge i_clk);
        check("rst_line", line, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        i_rst_n = 1'b1;
        act = 0;
        repeat (100) begin
            @(negedge i_clk);
            if (line || busy || ack || done) act++;
        end
        check("idle_quiet", act, 0);

        single(8'h85, 16'h1234, 1'b0, 1'b0);
        single(8'h1F, 16'hABCD, 1'b1, 1'b0);
        single(8'h85, 16'h1234, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            single(8'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // back-to-back with request held and inputs changed mid-frame
        cmd = 8'($urandom); data = 16'($urandom); no_data = 1'b0; inj = 1'b0;
        c2 = cmd; d2 = data; nd2 = no_data; ij2 = inj;
        req = 1'b1;
        wait_ack(n);
        check_frame(c2, d2, nd2, ij2, 100);
        c2 = cmd; d2 = data; nd2 = no_data; ij2 = inj;
        wait_ack(n);
        check("b2b_ack_gap", n, 9);
        req = 1'b0;
        check_frame(c2, d2, nd2, ij2, -1);
        gap_tail();

        // reset during the data field
        cmd = 8'($urandom); data = 16'($urandom); no_data = 1'b0;
        req = 1'b1;
        wait_ack(n);
        req = 1'b0;
        repeat (200) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("midrst_line", line, 0);
        check("midrst_busy", busy, 0);
        bad = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (done || line) bad++;
        end
        check("midrst_quiet", bad, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        single(8'($urandom), 16'($urandom), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
